// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : EX/WB pipeline register and writeback stage. Holds HI/LO and
//               the GPIO output register, selects WB write data, and feeds
//               the WB result back to EX as an operand bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_EX,
    input  logic [31:0] instruction_EX,
    input  logic        regwrite_EX,
    input  logic [1:0]  regsel_EX,
    input  logic        rdrt_EX,
    input  logic        enhilo_EX,
    input  logic        gpio_out_en_EX,
    input  logic        gpio_in_en_EX,
    input  logic [31:0] lo_EX,
    input  logic [31:0] hi_EX,
    input  logic [31:0] readdata1_EX,
    input  logic [31:0] readdata2_EX,
    input  logic [31:0] gpio_in,
    output logic [31:0] operand_a_EX,
    output logic [31:0] operand_b_EX,
    output logic        regwrite_WB,
    output logic [4:0]  writeaddr_WB,
    output logic [31:0] writedata_WB,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] gpio_out
);

    localparam logic [1:0] c_SEL_HI = 2'd1;
    localparam logic [1:0] c_SEL_LO = 2'd2;

    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_dest;
    logic        w_unused;
    logic [31:0] w_writedata;

    logic [31:0] r_gpio_sync1;
    logic [31:0] r_gpio_sync2;
    logic        r_regwrite_wb;
    logic [4:0]  r_writeaddr_wb;
    logic [1:0]  r_regsel_wb;
    logic        r_gpio_in_en_wb;
    logic [31:0] r_lo_wb;
    logic [31:0] r_gpio_in_wb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_gpio_out;

    assign w_rs     = instruction_EX[25:21];
    assign w_rt     = instruction_EX[20:16];
    assign w_rd     = instruction_EX[15:11];
    assign w_dest   = rdrt_EX ? w_rt : w_rd;
    assign w_unused = &{1'b0, instruction_EX[31:26], instruction_EX[10:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio_sync1    <= 32'd0;
            r_gpio_sync2    <= 32'd0;
            r_regwrite_wb   <= 1'b0;
            r_writeaddr_wb  <= 5'd0;
            r_regsel_wb     <= 2'd0;
            r_gpio_in_en_wb <= 1'b0;
            r_lo_wb         <= 32'd0;
            r_gpio_in_wb    <= 32'd0;
            r_hi            <= 32'd0;
            r_lo            <= 32'd0;
            r_gpio_out      <= 32'd0;
        end else begin
            // gpio_in is asynchronous to clk; two flops before it is used
            r_gpio_sync1 <= gpio_in;
            r_gpio_sync2 <= r_gpio_sync1;
            if (stall_EX) begin
                r_regwrite_wb <= 1'b0;
            end else begin
                r_regwrite_wb   <= regwrite_EX && (w_dest != 5'd0);
                r_writeaddr_wb  <= w_dest;
                r_regsel_wb     <= regsel_EX;
                r_gpio_in_en_wb <= gpio_in_en_EX;
                r_lo_wb         <= lo_EX;
                r_gpio_in_wb    <= r_gpio_sync2;
                if (enhilo_EX) begin
                    r_hi <= hi_EX;
                    r_lo <= lo_EX;
                end
                // raw register read: a producer of rs must not immediately precede
                if (gpio_out_en_EX) begin
                    r_gpio_out <= readdata1_EX;
                end
            end
        end
    end

    always_comb begin
        w_writedata = r_lo_wb;
        if (r_gpio_in_en_wb) begin
            w_writedata = r_gpio_in_wb;
        end else if (r_regsel_wb == c_SEL_HI) begin
            w_writedata = r_hi;
        end else if (r_regsel_wb == c_SEL_LO) begin
            w_writedata = r_lo;
        end
    end

    // r_regwrite_wb is never set for r0, so r0 is never bypassed
    assign operand_a_EX = (r_regwrite_wb && (r_writeaddr_wb == w_rs)) ? w_writedata : readdata1_EX;
    assign operand_b_EX = (r_regwrite_wb && (r_writeaddr_wb == w_rt)) ? w_writedata : readdata2_EX;

    assign regwrite_WB  = r_regwrite_wb;
    assign writeaddr_WB = r_writeaddr_wb;
    assign writedata_WB = w_writedata;
    assign hi_q         = r_hi;
    assign lo_q         = r_lo;
    assign gpio_out     = r_gpio_out;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage; expected WB results are
//               queued when an EX instruction is driven and checked one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall_EX;
    logic [31:0] instruction_EX;
    logic        regwrite_EX;
    logic [1:0]  regsel_EX;
    logic        rdrt_EX;
    logic        enhilo_EX;
    logic        gpio_out_en_EX;
    logic        gpio_in_en_EX;
    logic [31:0] lo_EX;
    logic [31:0] hi_EX;
    logic [31:0] readdata1_EX;
    logic [31:0] readdata2_EX;
    logic [31:0] gpio_in;
    logic [31:0] operand_a_EX;
    logic [31:0] operand_b_EX;
    logic        regwrite_WB;
    logic [4:0]  writeaddr_WB;
    logic [31:0] writedata_WB;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] gpio_out;

    typedef struct packed {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_EX       (stall_EX),
        .instruction_EX (instruction_EX),
        .regwrite_EX    (regwrite_EX),
        .regsel_EX      (regsel_EX),
        .rdrt_EX        (rdrt_EX),
        .enhilo_EX      (enhilo_EX),
        .gpio_out_en_EX (gpio_out_en_EX),
        .gpio_in_en_EX  (gpio_in_en_EX),
        .lo_EX          (lo_EX),
        .hi_EX          (hi_EX),
        .readdata1_EX   (readdata1_EX),
        .readdata2_EX   (readdata2_EX),
        .gpio_in        (gpio_in),
        .operand_a_EX   (operand_a_EX),
        .operand_b_EX   (operand_b_EX),
        .regwrite_WB    (regwrite_WB),
        .writeaddr_WB   (writeaddr_WB),
        .writedata_WB   (writedata_WB),
        .hi_q           (hi_q),
        .lo_q           (lo_q),
        .gpio_out       (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unknown write enables while not stalled are an upstream error
    always @(posedge clk) begin
        if (!rst && stall_EX === 1'b0) begin
            assert (!$isunknown(enhilo_EX) && !$isunknown(gpio_out_en_EX))
            else $error("FAIL ctrl_known: enhilo=%b gpio_out_en=%b", enhilo_EX, gpio_out_en_EX);
        end
    end

    task automatic set_ex(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rw, input logic [1:0] sel, input logic rdrt,
                          input logic [31:0] lo, input logic [31:0] rd1, input logic [31:0] rd2);
        stall_EX       = 1'b0;
        instruction_EX = {6'd0, rs, rt, rd, 11'd0};
        regwrite_EX    = rw;
        regsel_EX      = sel;
        rdrt_EX        = rdrt;
        enhilo_EX      = 1'b0;
        gpio_out_en_EX = 1'b0;
        gpio_in_en_EX  = 1'b0;
        lo_EX          = lo;
        hi_EX          = 32'd0;
        readdata1_EX   = rd1;
        readdata2_EX   = rd2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_ex(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        gpio_in = 32'd0;
        #12;
        checks++;
        if ({regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out} !== 134'd0) begin
            failures++;
            $display("FAIL reset_state: got rw=%b addr=%0d data=%h hi=%h lo=%h gpio=%h, expected all zero",
                     regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_writeback();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            set_ex(5'd1, 5'd2, (i == 0) ? 5'd3 : 5'd6, 1'b1, (i == 0) ? 2'd0 : 2'd3, 1'b0,
                   (i == 0) ? 32'h0000_0007 : 32'h0000_1234, 32'd0, 32'd0);
            exp_q.push_back('{1'b1, (i == 0) ? 5'd3 : 5'd6, (i == 0) ? 32'h7 : 32'h1234});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (regwrite_WB !== e.rw || writeaddr_WB !== e.addr || writedata_WB !== e.data) begin
                failures++;
                $display("FAIL writeback[%0d]: got rw=%b addr=%0d data=%h, expected rw=%b addr=%0d data=%h",
                         i, regwrite_WB, writeaddr_WB, writedata_WB, e.rw, e.addr, e.data);
            end
        end
    endtask

    task automatic test_hilo();
        exp_t e;
        // {rd, rw, sel, enhilo, hi, lo, exp_data}
        logic [4:0]  rd  [7] = '{5'd0, 5'd4, 5'd5, 5'd0, 5'd7, 5'd8, 5'd9};
        logic        rw  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  sel [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
        logic        en  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] hi  [7] = '{32'h1, 32'h0, 32'h0, 32'h2, 32'h4, 32'h0, 32'h0};
        logic [31:0] lo  [7] = '{32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0000_0BAD, 32'h3, 32'h5, 32'h77, 32'h66};
        logic [31:0] dat [7] = '{32'h0, 32'h1, 32'hFFFF_0000, 32'h0, 32'h5, 32'h4, 32'h5};
        for (int i = 0; i < 7; i++) begin
            set_ex(5'd1, 5'd2, rd[i], rw[i], sel[i], 1'b0, lo[i], 32'd0, 32'd0);
            enhilo_EX = en[i];
            hi_EX     = hi[i];
            exp_q.push_back('{rw[i], rd[i], dat[i]});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (regwrite_WB !== e.rw || (e.rw && (writeaddr_WB !== e.addr || writedata_WB !== e.data))) begin
                failures++;
                $display("FAIL hilo_wb[%0d]: got rw=%b addr=%0d data=%h, expected rw=%b addr=%0d data=%h",
                         i, regwrite_WB, writeaddr_WB, writedata_WB, e.rw, e.addr, e.data);
            end
            if (i == 0) begin
                checks++;
                if (hi_q !== 32'h1 || lo_q !== 32'hFFFF_0000) begin
                    failures++;
                    $display("FAIL hilo_load: got hi=%h lo=%h, expected hi=00000001 lo=ffff0000", hi_q, lo_q);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        set_ex(5'd0, 5'd2, 5'd31, 1'b1, 2'd0, 1'b1, 32'h10, 32'd0, 32'd0);
        exp_q.push_back('{1'b1, 5'd2, 32'h10});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (regwrite_WB !== e.rw || writeaddr_WB !== e.addr || writedata_WB !== e.data) begin
            failures++;
            $display("FAIL bypass_rt_dest: got rw=%b addr=%0d data=%h, expected rw=%b addr=%0d data=%h",
                     regwrite_WB, writeaddr_WB, writedata_WB, e.rw, e.addr, e.data);
        end
        set_ex(5'd2, 5'd9, 5'd3, 1'b1, 2'd0, 1'b0, 32'h20, 32'd0, 32'h77);
        #1;
        checks++;
        if (operand_a_EX !== 32'h10 || operand_b_EX !== 32'h77) begin
            failures++;
            $display("FAIL bypass_rs: got a=%h b=%h, expected a=00000010 b=00000077", operand_a_EX, operand_b_EX);
        end
        exp_q.push_back('{1'b1, 5'd3, 32'h20});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (regwrite_WB !== e.rw || writeaddr_WB !== e.addr || writedata_WB !== e.data) begin
            failures++;
            $display("FAIL bypass_add_wb: got rw=%b addr=%0d data=%h, expected rw=%b addr=%0d data=%h",
                     regwrite_WB, writeaddr_WB, writedata_WB, e.rw, e.addr, e.data);
        end
        set_ex(5'd9, 5'd3, 5'd0, 1'b1, 2'd0, 1'b0, 32'h55, 32'h99, 32'h88);
        #1;
        checks++;
        if (operand_b_EX !== 32'h20 || operand_a_EX !== 32'h99) begin
            failures++;
            $display("FAIL bypass_rt: got a=%h b=%h, expected a=00000099 b=00000020", operand_a_EX, operand_b_EX);
        end
        exp_q.push_back('{1'b0, 5'd0, 32'h0});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (regwrite_WB !== e.rw) begin
            failures++;
            $display("FAIL r0_write: got rw=%b, expected rw=%b", regwrite_WB, e.rw);
        end
        set_ex(5'd0, 5'd0, 5'd1, 1'b0, 2'd0, 1'b0, 32'h0, 32'hABC, 32'hDEF);
        #1;
        checks++;
        if (operand_a_EX !== 32'hABC || operand_b_EX !== 32'hDEF) begin
            failures++;
            $display("FAIL r0_no_bypass: got a=%h b=%h, expected a=00000abc b=00000def", operand_a_EX, operand_b_EX);
        end
        tick();
    endtask

    task automatic test_stall();
        exp_t e;
        set_ex(5'd1, 5'd2, 5'd8, 1'b1, 2'd0, 1'b0, 32'h88, 32'hFF, 32'd0);
        stall_EX       = 1'b1;
        enhilo_EX      = 1'b1;
        gpio_out_en_EX = 1'b1;
        hi_EX          = 32'h99;
        exp_q.push_back('{1'b0, 5'd0, 32'h0});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (regwrite_WB !== e.rw) begin
            failures++;
            $display("FAIL stall_bubble: got rw=%b, expected rw=%b", regwrite_WB, e.rw);
        end
        checks++;
        if (hi_q !== 32'h4 || lo_q !== 32'h5 || gpio_out !== 32'h0) begin
            failures++;
            $display("FAIL stall_hold: got hi=%h lo=%h gpio=%h, expected hi=00000004 lo=00000005 gpio=00000000",
                     hi_q, lo_q, gpio_out);
        end
    endtask

    task automatic test_gpio();
        exp_t e;
        logic [31:0] want [6] = '{32'h0, 32'h0, 32'h0, 32'h3C, 32'h3C, 32'h5A};
        set_ex(5'd1, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'hA5, 32'd0);
        gpio_out_en_EX = 1'b1;
        gpio_in        = 32'h3C;
        tick();
        checks++;
        if (gpio_out !== 32'hA5) begin
            failures++;
            $display("FAIL gpio_out: got %h, expected 000000a5", gpio_out);
        end
        // i=0..2: idle/reads while 0x3C settles; i=3..5: gpio_in changes to 0x5A at i=3
        for (int i = 0; i < 6; i++) begin
            set_ex(5'd0, 5'd0, 5'd10, (i >= 3), 2'd0, 1'b0, 32'h0, 32'd0, 32'd0);
            gpio_in_en_EX = (i >= 3);
            if (i == 3) gpio_in = 32'h5A;
            exp_q.push_back('{(i >= 3), 5'd10, want[i]});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (regwrite_WB !== e.rw || (e.rw && (writeaddr_WB !== e.addr || writedata_WB !== e.data))) begin
                failures++;
                $display("FAIL gpio_in[%0d]: got rw=%b addr=%0d data=%h, expected rw=%b addr=%0d data=%h",
                         i, regwrite_WB, writeaddr_WB, writedata_WB, e.rw, e.addr, e.data);
            end
        end
        checks++;
        if (gpio_out !== 32'hA5) begin
            failures++;
            $display("FAIL gpio_out_hold: got %h, expected 000000a5", gpio_out);
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        set_ex(5'd0, 5'd0, 5'd11, 1'b1, 2'd0, 1'b0, 32'h42, 32'd0, 32'd0);
        tick();
        set_ex(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h66, 32'd0, 32'd0);
        enhilo_EX = 1'b1;
        hi_EX     = 32'h77;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out} !== 134'd0) begin
            failures++;
            $display("FAIL reset_mid: got rw=%b addr=%0d data=%h hi=%h lo=%h gpio=%h, expected all zero",
                     regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out);
        end
        tick();
        rst = 1'b0;
        set_ex(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 32'd0);
        tick();
        checks++;
        if (hi_q !== 32'h0 || lo_q !== 32'h0) begin
            failures++;
            $display("FAIL reset_hilo_after: got hi=%h lo=%h, expected zero", hi_q, lo_q);
        end
        set_ex(5'd0, 5'd0, 5'd12, 1'b1, 2'd0, 1'b0, 32'h99, 32'd0, 32'd0);
        exp_q.push_back('{1'b1, 5'd12, 32'h99});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (regwrite_WB !== e.rw || writeaddr_WB !== e.addr || writedata_WB !== e.data) begin
            failures++;
            $display("FAIL reset_first_retire: got rw=%b addr=%0d data=%h, expected rw=%b addr=%0d data=%h",
                     regwrite_WB, writeaddr_WB, writedata_WB, e.rw, e.addr, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_hilo();
        test_bypass();
        test_stall();
        test_gpio();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

EX/WB pipeline register and writeback stage of the three-stage MIPS core, directly downstream of the EX-stage control decode. Captures the decoded EX control and ALU results on each clock and holds the architectural HI/LO registers and the GPIO output register. Selects the register-file write address and data in WB. Returns a WB→EX bypass so back-to-back dependent instructions read the correct operands.

## Interface
- No parameters; data width fixed at 32, register address at 5.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_EX  in  1  EX holds a bubble. The WB register loads a no-op; HI/LO and GPIO are not written.
- instruction_EX  in  32  EX instruction. rs=[25:21], rt=[20:16], rd=[15:11].
- regwrite_EX  in  1  instruction writes the register file.
- regsel_EX  in  2  writeback source: 0 ALU lo, 1 HI reg, 2 LO reg, 3 ALU lo.
- rdrt_EX  in  1  destination select: 1 = rt, 0 = rd.
- enhilo_EX  in  1  load HI/LO from ALU (mult/multu).
- gpio_out_en_EX  in  1  load GPIO output register (srl, shamt 0).
- gpio_in_en_EX  in  1  write data comes from GPIO input (sra, shamt 0).
- lo_EX, hi_EX  in  32 each  ALU result low/high words.
- readdata1_EX, readdata2_EX  in  32 each  raw register-file reads for rs/rt.
- gpio_in  in  32  external switch input, asynchronous to the core.
- operand_a_EX, operand_b_EX  out  32 each  bypassed rs/rt values to the ALU.
- regwrite_WB  out  1  register-file write enable.
- writeaddr_WB  out  5  register-file write address.
- writedata_WB  out  32  register-file write data.
- hi_q, lo_q  out  32 each  current HI/LO contents.
- gpio_out  out  32  GPIO output register.

## Operation
- WB pipeline register captures, each edge when stall_EX=0:
  - regwrite = regwrite_EX and the computed address ≠ 0;
  - address = rdrt_EX ? rt : rd;
  - regsel, gpio_in_en, lo_EX;
  - gpio_in, passed through a 2-flop synchronizer first.
- When stall_EX=1, the WB register loads regwrite=0; other fields are don't-care.
- When enhilo_EX=1 and stall_EX=0: hi_q←hi_EX and lo_q←lo_EX at the edge ending EX.
- When gpio_out_en_EX=1 and stall_EX=0: gpio_out←readdata1_EX (rs value, not bypassed; see Timing).
- writedata_WB (combinational from WB register):
  - gpio_in_en_WB → synchronized GPIO sample;
  - else regsel 1 → hi_q, 2 → lo_q, 0/3 → lo_WB.
- Bypass (combinational):
  - operand_a_EX = (regwrite_WB && writeaddr_WB==rs) ? writedata_WB : readdata1_EX;
  - operand_b_EX: same rule with rt and readdata2_EX.
- Register 0 is never written and never bypassed.
- enhilo_EX and gpio_out_en_EX must be 0/1 whenever stall_EX=0. X on them is an upstream error and is flagged by a bench assertion.

## Timing
- Reset (async, immediate): regwrite_WB=0, writeaddr_WB=0, lo_WB=0, regsel_WB=0, gpio_in_en_WB=0, hi_q=0, lo_q=0, gpio_out=0, synchronizer=0. Therefore writedata_WB=0.
- Latency: EX in cycle n → regwrite/writeaddr/writedata valid in cycle n+1. The register file writes at the edge ending n+1.
- mult in cycle n updates HI/LO at edge n→n+1. A mfhi/mflo in cycle n+1 reaches WB in n+2 and reads the new value. No interlock is needed.
- mult followed by mult: the second overwrites at its own edge. The last writer wins.
- Simultaneous enhilo_EX and regwrite_EX are legal and independent.
- Dependent instruction in n+1 receives the n result via bypass. A dependent instruction in n+2 reads the register file, which is write-first.
- GPIO-write rs operand: gpio_out takes raw readdata1_EX, not operand_a_EX. The instruction must not be scheduled directly after a producer of rs.
- GPIO input latency: 2 synchronizer cycles plus the WB register.
- Reset asserted mid-stream: the in-flight WB write is dropped and HI/LO/GPIO clear. After deassertion, the first EX instruction retires normally.

## Test plan
- Basic writeback: add rd=3, lo_EX=0x0000_0007 → next cycle regwrite_WB=1, writeaddr_WB=3, writedata_WB=7.
- HI/LO:
  - stimulus: mult with hi_EX=0x1, lo_EX=0xFFFF_0000, then mfhi rd=4, then mflo rd=5;
  - response: writedata_WB=0x1 to r4, then 0xFFFF_0000 to r5.
- Bypass: addi rt=2 with result 0x10, then add rs=2 with readdata1_EX=0 → operand_a_EX=0x10 in the second instruction's EX cycle. A write to r0 leaves regwrite_WB=0 and produces no bypass.
- Stall: stall_EX=1 with regwrite_EX=1, enhilo_EX=1 → regwrite_WB=0 next cycle; hi_q and lo_q unchanged.
- GPIO:
  - write with gpio_out_en_EX=1, readdata1_EX=0xA5 → gpio_out=0xA5 next cycle;
  - gpio_in=0x3C held, then GPIO read → writedata_WB=0x3C.
- Reset: assert rst mid-cycle during a mult in EX → all outputs 0 immediately. hi_q stays 0 after release.
